display_scan_reader: RTL and testbench
======================================

DISPLAY_SCAN_READER -- requirements
Module: display_scan_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width; must equal the display RAM data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, display RAM address width; frame size FRAME_PIXELS = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter LINE_PIXELS, default 8, pixels per line; FRAME_PIXELS must be an integer multiple of LINE_PIXELS.
REQ-004 SHALL have port clk  input  1  single clock for all logic, also driven to the RAM read clock.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse: frame in RAM is complete, begin scan-out.
REQ-007 SHALL have port rdaddress  output  ADDR_WIDTH  registered RAM read address.
REQ-008 SHALL have port q  input  DATA_WIDTH  RAM read data, valid one cycle after rdaddress is sampled.
REQ-009 SHALL have ports pix_data  output  DATA_WIDTH, pix_valid  output  1, pix_ready  input  1: pixel stream handshake.
REQ-010 SHALL have ports sof, eol, eof  output  1 each: first pixel of frame, last pixel of line, last pixel of frame; qualified by pix_valid.
REQ-011 SHALL have ports busy  output  1 (scan in progress) and frame_done  output  1 (one-cycle pulse).

Function
REQ-012 SHALL implement states IDLE, READ, DRAIN; IDLE->READ on start; READ->DRAIN after read of address FRAME_PIXELS-1 issued; DRAIN->IDLE when last pixel (eof) transferred.
REQ-013 SHALL ignore start while busy is high.
REQ-014 SHALL issue reads in ascending address order from 0 to FRAME_PIXELS-1, one per cycle maximum; rdaddress wraps to 0 after the last read.
REQ-015 SHALL track reads in flight (address stage and RAM output stage, max 2) and capture q into a 4-entry output FIFO one cycle after the RAM samples rdaddress.
REQ-016 SHALL issue a new read only when FIFO count plus in-flight reads is less than 4; no pixel is ever dropped or duplicated.
REQ-017 SHALL transfer a pixel on a cycle where pix_valid and pix_ready are both high; pix_data, sof, eol, eof SHALL hold stable while pix_valid high and pix_ready low.
REQ-018 SHALL sustain one pixel per cycle while pix_ready is held high.
REQ-019 SHALL give latency of 3 cycles: start high in cycle 0 -> rdaddress 0 in cycle 1 -> q in cycle 2 -> pix_valid with ram[0] in cycle 3.
REQ-020 SHALL assert sof on pixel index 0, eol on pixel index n where (n+1) mod LINE_PIXELS = 0, eof on pixel index FRAME_PIXELS-1 (eol also high then).
REQ-021 SHALL assert busy from the cycle after start is sampled until the cycle frame_done is asserted, inclusive of DRAIN.
REQ-022 SHALL pulse frame_done for exactly one cycle, the cycle after the eof transfer; busy low in that same cycle; a start in that cycle begins a new frame.
REQ-023 SHALL handle simultaneous FIFO push and pop in one cycle with count unchanged.

Reset
REQ-024 SHALL on reset_n low immediately clear: state IDLE, rdaddress 0, FIFO empty, in-flight 0, pix_valid 0, pix_data 0, sof/eol/eof 0, busy 0, frame_done 0.
REQ-025 SHALL on reset mid-frame discard all buffered and in-flight pixels; the next start rescans from address 0.

Verification
REQ-026 SHALL cover: RAM preloaded ram[i]=i, pix_ready held 1, start pulse -> 64 pixels 0..63 on consecutive cycles beginning cycle 3, sof on 0, eol on 7,15,..,63, eof on 63, frame_done one cycle after.
REQ-027 SHALL cover: pix_ready random 50% -> identical 64-value ordered sequence, outputs stable during stalls, no more than 4 pixels buffered.
REQ-028 SHALL cover: pix_ready low for 20 cycles after start -> rdaddress stops advancing at 4 issued reads, resumes with no loss when ready returns.
REQ-029 SHALL cover: second start pulse at pixel 10 -> ignored, frame completes normally with a single frame_done.
REQ-030 SHALL cover: reset_n low at pixel 30 -> all outputs 0 same cycle; new start after release -> pixels 0..63 from address 0.
REQ-031 SHALL cover: start in the frame_done cycle -> back-to-back frame, pixel 0 of second frame 3 cycles later.

Source files
------------

// File: rtl/display_scan_reader_if.sv
// Pixel stream interface between the scan reader and its downstream consumer.
//
// Signals:
//   pix_data  - pixel value, driven by the master
//   pix_valid - master has a pixel on pix_data
//   pix_ready - slave accepts the pixel this cycle
//   sof       - first pixel of the frame (qualified by pix_valid)
//   eol       - last pixel of a line (qualified by pix_valid)
//   eof       - last pixel of the frame (qualified by pix_valid)
//
// Modports: master (scan reader side), slave (consumer side).

interface display_scan_reader_if #(
    parameter int unsigned DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] pix_data;
    logic                  pix_valid;
    logic                  pix_ready;
    logic                  sof;
    logic                  eol;
    logic                  eof;

    modport master (
        output pix_data,
        output pix_valid,
        output sof,
        output eol,
        output eof,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        input  sof,
        input  eol,
        input  eof,
        output pix_ready
    );

endinterface

// File: rtl/display_scan_reader.sv
// Display scan reader: on a start pulse, reads a whole frame out of a synchronous
// display RAM in ascending address order and streams it as pixels with
// sof/eol/eof framing over a valid/ready handshake.
//
// Ports:
//   clk        - single clock (also the RAM read clock)
//   reset_n    - asynchronous active-low reset
//   start      - one-cycle pulse, frame in RAM is complete; ignored while busy
//   rdaddress  - registered RAM read address
//   q          - RAM read data, valid one cycle after rdaddress is sampled
//   pix        - pixel stream (master modport of display_scan_reader_if)
//   busy       - scan in progress
//   frame_done - one-cycle pulse the cycle after the eof pixel is transferred
//
// Pipeline: rdaddress (address stage) -> q (RAM output stage) -> 4-entry FIFO.
// A read is issued only when FIFO occupancy plus reads in flight is below 4, so
// the FIFO can never overflow regardless of pix_ready.

module display_scan_reader #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned LINE_PIXELS = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rdaddress,
    input  logic [DATA_WIDTH-1:0] q,
    display_scan_reader_if.master pix,
    output logic                  busy,
    output logic                  frame_done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] LINE_LAST = ADDR_WIDTH'(LINE_PIXELS - 1);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] rdaddress_q, rdaddress_d;
    logic                  addr_vld_q, addr_vld_d;  // read presented on rdaddress now
    logic                  ram_vld_q;               // q carries a requested word now

    logic [DATA_WIDTH-1:0] fifo_mem [4];
    logic [1:0]            wr_ptr_q, rd_ptr_q;
    logic [2:0]            count_q, count_d;

    logic [ADDR_WIDTH-1:0] pix_idx_q;   // index of the pixel at the FIFO head
    logic [ADDR_WIDTH-1:0] line_cnt_q;  // position of the head pixel within its line
    logic                  frame_done_q;

    logic       push;
    logic       pop;
    logic       fifo_valid;
    logic       head_eof;
    logic [2:0] occupancy;
    logic       can_issue;

    assign push       = ram_vld_q;
    assign fifo_valid = (count_q != 3'd0);
    assign pop        = fifo_valid && pix.pix_ready;
    assign head_eof   = fifo_valid && (pix_idx_q == LAST_ADDR);

    // Conservative credit check: ignores a same-cycle pop, which still leaves
    // enough headroom for one pixel per cycle in steady state.
    assign occupancy  = count_q + {2'b00, addr_vld_q} + {2'b00, ram_vld_q};
    assign can_issue  = (occupancy < 3'd4);

    always_comb begin
        state_d     = state_q;
        rdaddress_d = rdaddress_q;
        addr_vld_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Pipeline is empty in IDLE, so the first read needs no credit check.
                if (start) begin
                    state_d     = READ;
                    rdaddress_d = '0;
                    addr_vld_d  = 1'b1;
                end
            end
            READ: begin
                if (rdaddress_q == LAST_ADDR) begin
                    // Last read already issued; park the address at 0 for the next frame.
                    state_d     = DRAIN;
                    rdaddress_d = '0;
                end else if (can_issue) begin
                    rdaddress_d = rdaddress_q + ADDR_WIDTH'(1);
                    addr_vld_d  = 1'b1;
                end
            end
            DRAIN: begin
                if (pop && head_eof) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rdaddress_q  <= '0;
            addr_vld_q   <= 1'b0;
            ram_vld_q    <= 1'b0;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            count_q      <= 3'd0;
            pix_idx_q    <= '0;
            line_cnt_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rdaddress_q  <= rdaddress_d;
            addr_vld_q   <= addr_vld_d;
            ram_vld_q    <= addr_vld_q;
            count_q      <= count_d;
            frame_done_q <= pop && head_eof;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 2'd1;
                pix_idx_q <= pix_idx_q + ADDR_WIDTH'(1);
                if (line_cnt_q == LINE_LAST) begin
                    line_cnt_q <= '0;
                end else begin
                    line_cnt_q <= line_cnt_q + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // Storage needs no reset: outputs are gated by fifo_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= q;
        end
    end

    assign rdaddress     = rdaddress_q;
    assign busy          = (state_q != IDLE);
    assign frame_done    = frame_done_q;

    assign pix.pix_valid = fifo_valid;
    assign pix.pix_data  = fifo_valid ? fifo_mem[rd_ptr_q] : '0;
    assign pix.sof       = fifo_valid && (pix_idx_q == '0);
    assign pix.eol       = fifo_valid && (line_cnt_q == LINE_LAST);
    assign pix.eof       = head_eof;

endmodule

// File: tb/tb_display_scan_reader.sv
// Bench for display_scan_reader: RAM model with ram[i] = i, directed scenarios,
// and a scoreboard queue of expected pixels drained by a negedge monitor.

module tb_display_scan_reader;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int LP = 8;
    localparam int FP = 64;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sof;
        logic          eol;
        logic          eof;
    } pix_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] rdaddress;
    logic [DW-1:0] q = '0;
    logic          busy;
    logic          frame_done;

    display_scan_reader_if #(.DATA_WIDTH(DW)) pix ();

    display_scan_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LINE_PIXELS(LP)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .rdaddress (rdaddress),
        .q         (q),
        .pix       (pix),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [FP];
    always @(posedge clk) q <= ram[rdaddress];

    int   checks = 0;
    int   errors = 0;
    int   frame_done_cnt = 0;
    pix_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        pix_t e;
        for (int i = 0; i < FP; i++) begin
            e.d   = DW'(i);
            e.sof = (i == 0);
            e.eol = (((i + 1) % LP) == 0);
            e.eof = (i == FP - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            if (rnd) pix.pix_ready = 1'($urandom_range(0, 1));
            tick();
            if (frame_done) seen = 1'b1;
        end
        check("frame_done_seen", 32'(seen), 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 32'({rdaddress, pix.pix_valid, pix.pix_data, pix.sof, pix.eol, pix.eof,
                         busy, frame_done}), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every transfer, checks stall stability
    // and the frame_done pulse position.
    logic stall_prev = 1'b0;
    logic eof_prev = 1'b0;
    pix_t held = '0;

    always @(negedge clk) begin : monitor
        pix_t got;
        pix_t want;
        got = {pix.pix_data, pix.sof, pix.eol, pix.eof};
        if (!reset_n) begin
            stall_prev <= 1'b0;
            eof_prev   <= 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_hold", 32'({pix.pix_valid, got}), 32'({1'b1, held}));
            end
            if (eof_prev || frame_done) begin
                check("frame_done_timing", 32'(frame_done), 32'(eof_prev));
            end
            if (frame_done) begin
                check("busy_low_with_done", 32'(busy), 32'd0);
                frame_done_cnt <= frame_done_cnt + 1;
            end
            if (pix.pix_valid && pix.pix_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pixel actual=%0h required=none at %0t", got, $time);
                end else begin
                    want = exp_q.pop_front();
                    checks--;
                    check("pixel", 32'(got), 32'(want));
                end
            end
            stall_prev <= pix.pix_valid && !pix.pix_ready;
            held       <= got;
            eof_prev   <= pix.pix_valid && pix.pix_ready && pix.eof;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        int nvalid;
        int fd0;
        for (int i = 0; i < FP; i++) ram[i] = DW'(i);
        pix.pix_ready = 1'b1;

        // Reset state
        reset_n = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset_outputs");
        reset_n = 1'b1;
        tick();

        // Full-rate frame: pixel 0 in cycle 3, 64 consecutive pixels
        push_frame();
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        check("rdaddress_first", 32'(rdaddress), 32'd0);
        tick();
        check("no_valid_cycle2", 32'(pix.pix_valid), 32'd0);
        nvalid = 0;
        repeat (FP) begin
            tick();
            nvalid += int'(pix.pix_valid);
        end
        check("consecutive_pixels", 32'(nvalid), 32'd64);
        tick();
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        check("busy_low_at_done", 32'(busy), 32'd0);

        // Start in the frame_done cycle: back-to-back frame
        push_frame();
        pulse_start();
        check("b2b_busy", 32'(busy), 32'd1);
        tick();
        check("b2b_no_valid_cycle2", 32'(pix.pix_valid), 32'd0);
        tick();
        check("b2b_first_pixel", 32'({pix.pix_valid, pix.sof, pix.pix_data}), 32'h300);
        wait_done(1'b0);
        check("queue_empty_b2b", 32'(exp_q.size()), 32'd0);

        // Random backpressure
        tick();
        push_frame();
        pulse_start();
        wait_done(1'b1);
        pix.pix_ready = 1'b1;
        check("queue_empty_random", 32'(exp_q.size()), 32'd0);

        // Long stall: reads stop after 4 issued (addresses 0..3)
        tick();
        pix.pix_ready = 1'b0;
        push_frame();
        pulse_start();
        repeat (9) tick();
        check("stall_rdaddress_c10", 32'(rdaddress), 32'd3);
        repeat (10) tick();
        check("stall_rdaddress_c20", 32'(rdaddress), 32'd3);
        check("stall_valid_busy", 32'({pix.pix_valid, busy, pix.pix_data}), 32'h300);
        pix.pix_ready = 1'b1;
        wait_done(1'b0);
        check("queue_empty_stall", 32'(exp_q.size()), 32'd0);

        // Second start at pixel 10 is ignored
        tick();
        fd0 = frame_done_cnt;
        push_frame();
        pulse_start();
        repeat (12) tick();
        check("pixel10_on_bus", 32'(pix.pix_data), 32'd10);
        pulse_start();
        wait_done(1'b0);
        repeat (10) tick();
        check("single_frame_done", 32'(frame_done_cnt - fd0), 32'd1);
        check("idle_after_ignored_start", 32'(busy), 32'd0);
        check("queue_empty_restart", 32'(exp_q.size()), 32'd0);

        // Reset mid-frame at pixel 30, then a fresh frame from address 0
        push_frame();
        pulse_start();
        repeat (32) tick();
        check("pixel30_on_bus", 32'(pix.pix_data), 32'd30);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset_outputs");
        exp_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        push_frame();
        pulse_start();
        check("post_reset_rdaddress", 32'(rdaddress), 32'd0);
        wait_done(1'b0);
        check("queue_empty_post_reset", 32'(exp_q.size()), 32'd0);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
